hdv_axis_stream_source: RTL and testbench



---
 rtl/hdv_stream_pkg.sv | 31 +++
 rtl/hdv_sync_fifo.sv | 83 ++++++++
 rtl/hdv_axis_stream_source.sv | 182 ++++++++++++++++++
 tb/tb_hdv_axis_stream_source.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/hdv_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hdv_stream_pkg
// Description : Shared types and constants for the hypervector AXI4-Stream
//               transmit path. Provides the transmit FSM state encoding,
//               default geometry constants, and the FIFO pointer-width helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package hdv_stream_pkg;

  // Transmit FSM encoding.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    BLOCKED = 2'd2
  } stream_state_e;

  localparam int unsigned c_DATA_W       = 32;
  localparam int unsigned c_DEPTH        = 16;
  localparam int unsigned c_WORDS_PER_HV = 32;
  localparam int unsigned c_STALL_LIMIT  = 1024;

  // Pointer width for a circular FIFO of 'depth' entries: the address bits
  // plus one wrap bit that tells full apart from empty.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage : hdv_stream_pkg
`default_nettype wire

// File: rtl/hdv_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : hdv_sync_fifo
// Description : Single-clock circular FIFO with wrap-bit pointers. The head
//               word is presented combinationally and stays put until popped.
// Ports       : clk        - clock, rising edge
//               rst_n      - asynchronous active-low reset
//               i_push     - write request (ignored when full)
//               i_data     - write data
//               i_pop      - read request (ignored when empty)
//               o_full     - no free entry
//               o_empty    - no stored entry
//               o_last_one - exactly one entry stored
//               o_head     - oldest stored word
// Revision    : 1.0 - initial release
// ============================================================================
module hdv_sync_fifo
  import hdv_stream_pkg::*;
#(
  parameter int unsigned DATA_W = c_DATA_W,
  parameter int unsigned DEPTH  = c_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_last_one,
  output logic [DATA_W-1:0] o_head
);

  localparam int unsigned c_PW = ptr_width(DEPTH);
  localparam int unsigned c_AW = c_PW - 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [c_PW-1:0]   r_wptr;
  logic [c_PW-1:0]   r_rptr;
  logic [c_PW-1:0]   w_count;
  logic              w_push;
  logic              w_pop;

  // Full: same slot, opposite lap. Empty: identical pointers.
  assign o_full     = (r_wptr[c_AW] != r_rptr[c_AW]) &&
                      (r_wptr[c_AW-1:0] == r_rptr[c_AW-1:0]);
  assign o_empty    = (r_wptr == r_rptr);
  assign w_count    = r_wptr - r_rptr;
  assign o_last_one = (w_count == c_PW'(1));

  // Full blocks a push even when a pop happens in the same cycle.
  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  assign o_head = r_mem[r_rptr[c_AW-1:0]];

  // Storage is cleared on reset so the head reads as zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[r_wptr[c_AW-1:0]] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + c_PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + c_PW'(1);
      end
    end
  end

endmodule : hdv_sync_fifo
`default_nettype wire

// File: rtl/hdv_axis_stream_source.sv
`default_nettype none
// ============================================================================
// Module      : hdv_axis_stream_source
// Description : AXI4-Stream transmitter feeding hypervector words to the HDC
//               engine. Buffers host words in a FIFO, frames them with TLAST
//               every WORDS_PER_HV words, counts completed hypervectors and
//               watches for prolonged backpressure with a sticky block flag.
// Ports       : ap_clk        - clock, rising edge
//               ap_rst_n      - asynchronous active-low reset
//               in_valid      - upstream word valid
//               in_ready      - FIFO not full
//               in_data       - upstream word
//               m_axis_tdata  - stream data (FIFO head)
//               m_axis_tvalid - stream valid (FIFO not empty)
//               m_axis_tready - engine ready
//               m_axis_tlast  - last word of the current hypervector
//               blk_clr       - pulse clearing block and the stall counter
//               block         - sticky backpressure-stall flag
//               hv_sent       - completed hypervector count, wraps at 2^16
// Revision    : 1.0 - initial release
// ============================================================================
module hdv_axis_stream_source
  import hdv_stream_pkg::*;
#(
  parameter int unsigned DATA_W       = c_DATA_W,
  parameter int unsigned DEPTH        = c_DEPTH,
  parameter int unsigned WORDS_PER_HV = c_WORDS_PER_HV,
  parameter int unsigned STALL_LIMIT  = c_STALL_LIMIT
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  input  logic              blk_clr,
  output logic              block,
  output logic [15:0]       hv_sent
);

  // A single-word hypervector still needs a one-bit counter.
  localparam int unsigned c_WCW = (WORDS_PER_HV > 1) ? $clog2(WORDS_PER_HV) : 1;
  localparam int unsigned c_SCW = $clog2(STALL_LIMIT + 1);
  localparam logic [c_WCW-1:0] c_WLAST = c_WCW'(WORDS_PER_HV - 1);
  localparam logic [c_SCW-1:0] c_SLIM  = c_SCW'(STALL_LIMIT);

  logic              w_full;
  logic              w_empty;
  logic              w_last_one;
  logic              w_push;
  logic              w_pop;
  logic              w_drain;
  logic              w_stalled;
  logic              w_block_set;
  logic [c_SCW-1:0]  w_stall_nxt;
  logic [c_WCW-1:0]  r_wcnt;
  logic [c_SCW-1:0]  r_stall_cnt;
  logic              r_block;
  logic [15:0]       r_hv_sent;
  stream_state_e     r_state;
  stream_state_e     w_state_nxt;

  assign in_ready      = !w_full;
  assign m_axis_tvalid = !w_empty;
  assign w_push        = in_valid && in_ready;
  assign w_pop         = m_axis_tvalid && m_axis_tready;
  // The word being popped is the only one left and nothing refills the FIFO.
  assign w_drain       = w_pop && w_last_one && !w_push;

  hdv_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk        (ap_clk),
    .rst_n      (ap_rst_n),
    .i_push     (w_push),
    .i_data     (in_data),
    .i_pop      (w_pop),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_last_one (w_last_one),
    .o_head     (m_axis_tdata)
  );

  // --------------------------------------------------------------------------
  // Hypervector framing
  // --------------------------------------------------------------------------
  assign m_axis_tlast = (r_wcnt == c_WLAST);
  assign hv_sent      = r_hv_sent;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_wcnt    <= '0;
      r_hv_sent <= '0;
    end else if (w_pop) begin
      if (m_axis_tlast) begin
        r_wcnt    <= '0;
        r_hv_sent <= r_hv_sent + 16'd1;
      end else begin
        r_wcnt <= r_wcnt + c_WCW'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stall watchdog
  // --------------------------------------------------------------------------
  assign w_stalled = m_axis_tvalid && !m_axis_tready;

  always_comb begin
    w_stall_nxt = r_stall_cnt;
    if (!w_stalled) begin
      w_stall_nxt = '0;
    end else if (r_stall_cnt != c_SLIM) begin
      w_stall_nxt = r_stall_cnt + c_SCW'(1);
    end
  end

  // Set on the edge that completes the limit-th consecutive stalled cycle.
  assign w_block_set = (w_stall_nxt == c_SLIM);
  assign block       = r_block;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_stall_cnt <= '0;
      r_block     <= 1'b0;
    end else if (blk_clr) begin
      // Clear takes priority over a coincident set.
      r_stall_cnt <= '0;
      r_block     <= 1'b0;
    end else begin
      r_stall_cnt <= w_stall_nxt;
      if (w_block_set) begin
        r_block <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Transmit FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_push) begin
          w_state_nxt = SEND;
        end
      end
      SEND: begin
        if (w_drain) begin
          w_state_nxt = IDLE;
        end else if (w_block_set && !blk_clr) begin
          w_state_nxt = BLOCKED;
        end
      end
      BLOCKED: begin
        if (w_drain) begin
          w_state_nxt = IDLE;
        end else if (w_pop) begin
          w_state_nxt = SEND;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

endmodule : hdv_axis_stream_source
`default_nettype wire

// File: tb/tb_hdv_axis_stream_source.sv
`default_nettype none
// ============================================================================
// Module      : tb_hdv_axis_stream_source
// Description : Scoreboard bench for hdv_axis_stream_source. Accepted pushes
//               queue their expected words; a negedge monitor pops and checks
//               TDATA and TLAST on every handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hdv_axis_stream_source;

  localparam int DW  = 32;
  localparam int WPH = 32;

  logic          ap_clk        = 1'b0;
  logic          ap_rst_n      = 1'b0;
  logic          in_valid      = 1'b0;
  logic [DW-1:0] in_data       = '0;
  logic          m_axis_tready = 1'b0;
  logic          blk_clr       = 1'b0;
  logic          in_ready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tlast;
  logic          block;
  logic [15:0]   hv_sent;

  int            total    = 0;
  int            bad      = 0;
  int            hs_cnt   = 0;
  int            word_idx = 0;
  logic [DW-1:0] sb_q[$];

  always #5 ap_clk = ~ap_clk;

  hdv_axis_stream_source #(
    .DATA_W       (DW),
    .DEPTH        (16),
    .WORDS_PER_HV (WPH),
    .STALL_LIMIT  (1024)
  ) dut (
    .ap_clk        (ap_clk),
    .ap_rst_n      (ap_rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .blk_clr       (blk_clr),
    .block         (block),
    .hv_sent       (hv_sent)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a handshake is pending when valid and ready are both high
  // mid-cycle; the scoreboard supplies the word and the framing model the TLAST.
  always @(negedge ap_clk) begin
    if (ap_rst_n && m_axis_tvalid && m_axis_tready) begin
      hs_cnt++;
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_word: got %0h expected none", m_axis_tdata);
      end else begin
        check("tdata", m_axis_tdata, sb_q.pop_front());
        check("tlast", m_axis_tlast, (word_idx == WPH - 1));
        word_idx = (word_idx == WPH - 1) ? 0 : word_idx + 1;
      end
    end
  end

  task automatic push_words(input int n, input logic [DW-1:0] base, output int acc);
    acc = 0;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = base + DW'(i);
      @(negedge ap_clk);
      if (in_ready) begin
        sb_q.push_back(in_data);
        acc++;
      end
      @(posedge ap_clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (m_axis_tvalid && n < 200) begin
      @(posedge ap_clk);
      #1;
      n++;
    end
    check(name, m_axis_tvalid, 1'b0);
  endtask

  task automatic pulse_clr();
    blk_clr = 1'b1;
    @(posedge ap_clk);
    #1;
    blk_clr = 1'b0;
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc;
    int hs0;

    // Reset values
    repeat (3) @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b1;
    @(posedge ap_clk);
    #1;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_tvalid", m_axis_tvalid, 1'b0);
    check("rst_tdata", m_axis_tdata, 32'h0);
    check("rst_tlast", m_axis_tlast, 1'b0);
    check("rst_block", block, 1'b0);
    check("rst_hv_sent", hv_sent, 16'd0);

    // One full hypervector at full throughput
    m_axis_tready = 1'b1;
    push_words(32, 32'hA000_0000, acc);
    check("hv1_accepted", acc, 32);
    wait_drain("hv1_drain");
    check("hv1_handshakes", hs_cnt, 32);
    check("hv1_hv_sent", hv_sent, 16'd1);
    check("hv1_block", block, 1'b0);

    // Fill the FIFO against backpressure; 17th push refused
    m_axis_tready = 1'b0;
    hs0 = hs_cnt;
    push_words(1, 32'hB000_0000, acc);
    check("fill_head_first", m_axis_tdata, 32'hB000_0000);
    push_words(16, 32'hB000_0001, acc);
    check("fill_accepted", acc, 15);
    check("fill_in_ready", in_ready, 1'b0);
    check("fill_head_held", m_axis_tdata, 32'hB000_0000);
    check("fill_no_handshake", hs_cnt, hs0);
    m_axis_tready = 1'b1;
    wait_drain("fill_drain");
    check("fill_hv_sent", hv_sent, 16'd1);

    // Stall for exactly the limit
    m_axis_tready = 1'b0;
    push_words(1, 32'hC000_0000, acc);
    repeat (1023) @(posedge ap_clk);
    #1;
    check("stall1023_block", block, 1'b0);
    @(posedge ap_clk);
    #1;
    check("stall1024_block", block, 1'b1);
    check("blocked_data_held", m_axis_tdata, 32'hC000_0000);
    m_axis_tready = 1'b1;
    wait_drain("blocked_drain");
    check("block_sticky", block, 1'b1);
    pulse_clr();
    check("block_cleared", block, 1'b0);

    // Stall 1023, one handshake, stall 1023 again
    m_axis_tready = 1'b0;
    push_words(2, 32'hD000_0000, acc);
    repeat (1022) @(posedge ap_clk);
    #1;
    m_axis_tready = 1'b1;
    @(posedge ap_clk);
    #1;
    m_axis_tready = 1'b0;
    check("restart_head", m_axis_tdata, 32'hD000_0001);
    repeat (1023) @(posedge ap_clk);
    #1;
    check("restart_block", block, 1'b0);
    m_axis_tready = 1'b1;
    wait_drain("restart_drain");

    // blk_clr coincides with the limit-th stalled cycle
    m_axis_tready = 1'b0;
    push_words(1, 32'hE000_0000, acc);
    repeat (1023) @(posedge ap_clk);
    #1;
    pulse_clr();
    check("clr_wins_block", block, 1'b0);
    repeat (1023) @(posedge ap_clk);
    #1;
    check("clr_counter_restart", block, 1'b0);
    @(posedge ap_clk);
    #1;
    check("clr_then_limit", block, 1'b1);
    m_axis_tready = 1'b1;
    wait_drain("clr_drain");
    pulse_clr();
    check("clr_final", block, 1'b0);

    // Reset in the middle of a hypervector
    push_words(10, 32'hF000_0000, acc);
    wait_drain("partial_drain");
    m_axis_tready = 1'b0;
    push_words(5, 32'h9000_0000, acc);
    ap_rst_n = 1'b0;
    sb_q.delete();
    word_idx = 0;
    @(negedge ap_clk);
    check("midrst_tvalid", m_axis_tvalid, 1'b0);
    check("midrst_hv_sent", hv_sent, 16'd0);
    check("midrst_in_ready", in_ready, 1'b1);
    @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b1;
    m_axis_tready = 1'b1;
    push_words(32, 32'h5000_0000, acc);
    wait_drain("post_rst_drain");
    check("post_rst_hv_sent", hv_sent, 16'd1);
    check("post_rst_sb_empty", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_hdv_axis_stream_source
`default_nettype wire
